// File: rtl/p16_uart_pkg.sv
// Shared constants, FSM state type and baud-divider helper for the UART receive path.
package p16_uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Rounded integer division: clock cycles per serial bit.
    function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/p16_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head read.
module p16_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/p16_uart_rx.sv
// 8N1 UART receiver with majority-vote sampling feeding a small valid/ready FIFO.
module p16_uart_rx
    import p16_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 6000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    rx_state_t              state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   sync1, sync2;
    logic [2:0]             hist;
    logic                   sample;
    logic                   push_c;
    logic                   frame_err_n, overrun_n;
    logic                   fifo_empty, fifo_full;
    logic                   pop;

    assign sample = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
    assign pop    = valid && ready;
    assign valid  = !fifo_empty;

    // Synchroniser and 3-sample history for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 3'b111;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= {hist[1:0], sync2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            busy      <= (state_n != IDLE);
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        push_c      = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!sync2) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    cnt_n   = '0;
                    shreg_n = {sample, shreg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Back to IDLE on the stop sample so a tight next start bit is caught.
                if (cnt == CNT_W'(DIV - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!sample) begin
                        frame_err_n = 1'b1;
                    end else if (!fifo_full || pop) begin
                        push_c = 1'b1;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    p16_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata (shreg),
        .pop   (pop),
        .rdata (data_out),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
